bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: slave cycles allowed before error termination (range 2..255).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on error termination.
REQ-003 SHALL have one clock; reset is asynchronous and active-low (ports clk and rst_ni).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 m0_stb_i, m0_we_i  input  1 each  master 0 (CPU) strobe, write enable.
REQ-007 m0_adr_i, m0_dat_i  input  32 each  master 0 address, write data; m0_sel_i  input  4  byte selects.
REQ-008 m0_ack_o, m0_err_o  output  1 each  master 0 completion, error flag; m0_dat_o  output  32  read data.
REQ-009 m1_* ports SHALL mirror m0_* exactly for master 1 (DMA/video fetch).
REQ-010 s_stb_o, s_we_o  output  1; s_adr_o, s_dat_o  output  32; s_sel_o  output  4  shared slave bus.
REQ-011 s_ack_i  input  1; s_dat_i  input  32  slave completion, read data.
REQ-012 gnt_o  output  2  one-hot current grant, for debug/LED.

Function
REQ-013 States SHALL be IDLE, BUSY, HOLD; one transaction per grant.
REQ-014 IDLE: if any mN_stb_i, SHALL register grant to requester; both requesting -> master named by round-robin pointer rr; next state BUSY.
REQ-015 Arbitration latency SHALL be exactly 1 cycle: stb in IDLE at edge t -> s_stb_o high during cycle t+1.
REQ-016 BUSY: s_* outputs SHALL be combinationally muxed from granted master; s_stb_o = granted mN_stb_i; ungranted master sees ack=0, err=0.
REQ-017 BUSY, s_ack_i=1: granted mN_ack_o=1 same cycle (combinational), rr <= other master, next state HOLD.
REQ-018 HOLD: s_stb_o=0, all acks 0, one cycle; next IDLE (guarantees a master dropping stb after ack is never re-granted spuriously).
REQ-019 mN_dat_o SHALL equal s_dat_i when that master is granted, else 0; on error, ERR_DATA.
REQ-020 BUSY, granted stb drops without ack (abort): SHALL go IDLE next cycle, rr unchanged, no ack/err issued.
REQ-021 Watchdog: 8-bit counter cleared on entry to BUSY, incremented each BUSY cycle without s_ack_i.
REQ-022 Counter reaching TIMEOUT_CYC-1 with no s_ack_i: SHALL assert mN_ack_o=1 and mN_err_o=1 for that one cycle, s_stb_o=0 that cycle, rr <= other master, next HOLD.
REQ-023 s_ack_i and timeout in same cycle: s_ack_i SHALL win, err_o=0.
REQ-024 s_ack_i while IDLE or HOLD SHALL be ignored.
REQ-025 Master requesting alone SHALL be granted regardless of rr; rr affects ties only.
REQ-026 Starvation bound: a held request SHALL be granted within two transactions of the other master.

Reset
REQ-027 On rst_ni=0: state IDLE, gnt_o=2'b00, rr=master 0, watchdog=0, all ack/err/s_stb_o=0, s_we_o=0, s_sel_o=0, s_adr_o=0, s_dat_o=0.
REQ-028 Reset mid-transaction SHALL drop s_stb_o asynchronously; no ack to any master; first post-reset transaction arbitrated from IDLE.

Structure
REQ-029 Shared package bus_pkg SHALL hold state enum (IDLE/BUSY/HOLD), ERR_DATA default, TIMEOUT_CYC default, bus width constants.
REQ-030 Watchdog counter SHALL be sub-module bus_watchdog (clear, enable, limit -> expire pulse).

Verification
REQ-031 m0 read at 0x00000010 alone, slave ack = stb -> s_stb_o at t+1, m0_ack_o at t+1 with s_dat_i, HOLD at t+2, gnt_o 01.
REQ-032 m0, m1 request same cycle after reset -> m0 first, then m1 after HOLD; repeat with both held -> grants alternate 01,10,01,10.
REQ-033 m1 write 0x02000000, slave never acks, TIMEOUT_CYC=4 -> m1_ack_o=m1_err_o=1 on 4th BUSY cycle, m1_dat_o=DEADBEEF, s_stb_o=0 that cycle.
REQ-034 s_ack_i on cycle TIMEOUT_CYC-1 -> normal ack, err_o=0.
REQ-035 m0 drops stb in BUSY before ack -> IDLE next cycle, no ack, rr still 0.
REQ-036 rst_ni low mid-BUSY -> s_stb_o=0 immediately, gnt_o=00; release -> fresh arbitration, m0 priority.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master shared-bus arbiter.
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int WDOG_W = 8;

  localparam int unsigned       TIMEOUT_CYC_DEF = 64;
  localparam logic [DATA_W-1:0] ERR_DATA_DEF    = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One-hot grant choice: a lone requester always wins, rr only breaks ties
  // (rr=0 favours master 0, rr=1 favours master 1).
  function automatic logic [1:0] pick_grant(input logic req0, input logic req1,
                                            input logic rr);
    logic [1:0] gnt;
    gnt = 2'b00;
    if (req0 && req1) gnt = rr ? 2'b10 : 2'b01;
    else if (req0)    gnt = 2'b01;
    else if (req1)    gnt = 2'b10;
    return gnt;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Slave-response watchdog: counts stalled bus cycles and pulses expire on the
// cycle the count reaches limit-1 while still enabled.
module bus_watchdog
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              clear,
  input  logic              enable,
  input  logic [WDOG_W-1:0] limit,
  output logic              expire
);

  logic [WDOG_W-1:0] count_reg;

  // Stall counter: held at zero outside a transaction, steps on each stalled cycle.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)     count_reg <= '0;
    else if (clear)  count_reg <= '0;
    else if (enable) count_reg <= count_reg + WDOG_W'(1);
  end

  assign expire = enable && (count_reg == (limit - WDOG_W'(1)));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a single shared slave bus, one
// transaction per grant, with a watchdog that error-terminates a silent slave.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [DATA_W-1:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DATA_W-1:0] m0_dat_o,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  output logic [SEL_W-1:0]  s_sel_o,
  input  logic              s_ack_i,
  input  logic [DATA_W-1:0] s_dat_i,
  output logic [1:0]        gnt_o
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYC);

  state_t     state_reg, state_next;
  logic [1:0] gnt_reg, gnt_next;
  logic       rr_reg, rr_next;

  logic g_stb;
  logic wd_clear, wd_enable, wd_expire;
  logic done, done_err;

  // Strobe of whichever master currently holds the grant.
  assign g_stb = gnt_reg[1] ? m1_stb_i : m0_stb_i;

  // Watchdog runs only while a live request waits on the slave.
  assign wd_clear  = (state_reg != BUSY);
  assign wd_enable = (state_reg == BUSY) && g_stb && !s_ack_i;

  bus_watchdog u_watchdog (
    .clk    (clk),
    .rst_ni (rst_ni),
    .clear  (wd_clear),
    .enable (wd_enable),
    .limit  (WDOG_LIMIT),
    .expire (wd_expire)
  );

  // Arbiter state, registered grant and round-robin pointer.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      gnt_reg   <= 2'b00;
      rr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      rr_reg    <= rr_next;
    end
  end

  // Next-state decode, slave bus mux and per-master completion signals.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    rr_next    = rr_reg;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_sel_o    = '0;
    done       = 1'b0;
    done_err   = 1'b0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_dat_o   = '0;

    case (state_reg)
      IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          gnt_next   = pick_grant(m0_stb_i, m1_stb_i, rr_reg);
          state_next = BUSY;
        end
      end
      BUSY: begin
        s_stb_o = g_stb && !wd_expire;
        s_we_o  = gnt_reg[1] ? m1_we_i  : m0_we_i;
        s_adr_o = gnt_reg[1] ? m1_adr_i : m0_adr_i;
        s_dat_o = gnt_reg[1] ? m1_dat_i : m0_dat_i;
        s_sel_o = gnt_reg[1] ? m1_sel_i : m0_sel_i;
        if (!g_stb) begin
          // Master withdrew before completion: no ack, pointer untouched.
          state_next = IDLE;
          gnt_next   = 2'b00;
        end else if (s_ack_i || wd_expire) begin
          // A real slave ack beats a simultaneous watchdog expiry.
          done       = 1'b1;
          done_err   = !s_ack_i;
          rr_next    = gnt_reg[0];
          state_next = HOLD;
        end
        m0_ack_o = done && gnt_reg[0];
        m0_err_o = done_err && gnt_reg[0];
        m0_dat_o = !gnt_reg[0] ? '0 : (done_err ? ERR_DATA : s_dat_i);
        m1_ack_o = done && gnt_reg[1];
        m1_err_o = done_err && gnt_reg[1];
        m1_dat_o = !gnt_reg[1] ? '0 : (done_err ? ERR_DATA : s_dat_i);
      end
      HOLD: begin
        state_next = IDLE;
        gnt_next   = 2'b00;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 2'b00;
      end
    endcase
  end

  assign gnt_o = gnt_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus queues expected completions, a
// monitor pops and compares them whenever a master sees ack.
module tb_bus_arbiter;

  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic [1:0]  gnt_o;

  typedef struct packed {
    logic        mst;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .gnt_o(gnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic expect_ack(input logic mst, input logic err, input logic [31:0] dat);
    exp_t e;
    e.mst = mst;
    e.err = err;
    e.dat = dat;
    sb.push_back(e);
  endtask

  task automatic quiet();
    m0_stb_i = 1'b0;
    m1_stb_i = 1'b0;
    s_ack_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // Monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (m0_ack_o || m1_ack_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_master", {30'd0, m1_ack_o, m0_ack_o}, e.mst ? 32'd2 : 32'd1);
        if (e.mst) begin
          chk("ack_err", 32'(m1_err_o), 32'(e.err));
          chk("ack_data", m1_dat_o, e.dat);
          chk("other_dat", m0_dat_o, 32'd0);
          chk("other_err", 32'(m0_err_o), 32'd0);
        end else begin
          chk("ack_err", 32'(m0_err_o), 32'(e.err));
          chk("ack_data", m0_dat_o, e.dat);
          chk("other_dat", m1_dat_o, 32'd0);
          chk("other_err", 32'(m1_err_o), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // Reset with busy-looking inputs: every output must still read zero.
    rst_ni   = 1'b0;
    m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 32'hFFFF_FFFF;
    m0_dat_i = 32'hCAFE_0000; m0_sel_i = 4'hF;
    m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h8888_8888;
    m1_dat_i = 32'hCAFE_1111; m1_sel_i = 4'hF;
    s_ack_i  = 1'b1; s_dat_i = 32'h5A5A_5A5A;
    tick();
    tick();
    mid();
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_s_we", 32'(s_we_o), 32'd0);
    chk("rst_s_sel", 32'(s_sel_o), 32'd0);
    chk("rst_s_adr", s_adr_o, 32'd0);
    chk("rst_s_dat", s_dat_o, 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_acks", {28'd0, m1_err_o, m0_err_o, m1_ack_o, m0_ack_o}, 32'd0);
    tick();
    quiet();
    rst_ni = 1'b1;
    tick();

    // m0 single read, slave acks in the first bus cycle.
    m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h0000_0010; m0_sel_i = 4'hF;
    mid(); chk("t1_idle_stb", 32'(s_stb_o), 32'd0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    expect_ack(1'b0, 1'b0, 32'h1234_5678);
    mid();
    chk("t1_busy_stb", 32'(s_stb_o), 32'd1);
    chk("t1_adr", s_adr_o, 32'h0000_0010);
    chk("t1_we", 32'(s_we_o), 32'd0);
    chk("t1_gnt", 32'(gnt_o), 32'd1);
    tick();
    m0_stb_i = 1'b0;  // s_ack_i left high: must be ignored in HOLD and IDLE
    mid(); chk("t1_hold_stb", 32'(s_stb_o), 32'd0);
    tick();
    mid(); chk("t1_idle_gnt", 32'(gnt_o), 32'd0);
    tick();
    quiet();

    // Both masters held: m0 first after reset, then strict alternation.
    do_reset();
    m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 32'h0000_0100;
    m0_dat_i = 32'h1111_0000; m0_sel_i = 4'h3;
    m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h0000_0200;
    m1_dat_i = 32'h2222_0000; m1_sel_i = 4'hC;
    for (int k = 0; k < 4; k++) begin
      s_ack_i = 1'b0;
      mid(); chk("t2_idle_stb", 32'(s_stb_o), 32'd0);
      tick();
      s_ack_i = 1'b1; s_dat_i = 32'hA000_0000 + 32'(k);
      expect_ack(k[0], 1'b0, 32'hA000_0000 + 32'(k));
      mid();
      chk("t2_gnt", 32'(gnt_o), k[0] ? 32'd2 : 32'd1);
      chk("t2_adr", s_adr_o, k[0] ? 32'h0000_0200 : 32'h0000_0100);
      chk("t2_wdat", s_dat_o, k[0] ? 32'h2222_0000 : 32'h1111_0000);
      chk("t2_sel", 32'(s_sel_o), k[0] ? 32'hC : 32'h3);
      tick();
      s_ack_i = 1'b0;
      mid(); chk("t2_hold_stb", 32'(s_stb_o), 32'd0);
      tick();
    end
    quiet();

    // m1 write to a silent slave: error termination on the 4th bus cycle.
    m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h0200_0000; m1_dat_i = 32'h5555_AAAA;
    tick();
    for (int b = 1; b <= 3; b++) begin
      mid();
      chk("t3_stall_stb", 32'(s_stb_o), 32'd1);
      chk("t3_stall_err", 32'(m1_err_o), 32'd0);
      tick();
    end
    expect_ack(1'b1, 1'b1, ERR_VAL);
    mid();
    chk("t3_to_stb", 32'(s_stb_o), 32'd0);
    chk("t3_to_gnt", 32'(gnt_o), 32'd2);
    tick();
    m1_stb_i = 1'b0;
    tick();

    // m0 read acked on the very cycle the watchdog would fire: normal ack.
    m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h0000_0030;
    tick();
    for (int b = 1; b <= 3; b++) begin
      mid(); chk("t4_stall_stb", 32'(s_stb_o), 32'd1);
      tick();
    end
    s_ack_i = 1'b1; s_dat_i = 32'h0BAD_F00D;
    expect_ack(1'b0, 1'b0, 32'h0BAD_F00D);
    mid();
    chk("t4_stb", 32'(s_stb_o), 32'd1);
    chk("t4_err", 32'(m0_err_o), 32'd0);
    tick();
    quiet();
    tick();

    // m0 aborts mid-transaction: back to IDLE next cycle with rr still at m0.
    do_reset();
    m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0040;
    tick();
    mid(); chk("t5_busy_gnt", 32'(gnt_o), 32'd1);
    tick();
    m0_stb_i = 1'b0;
    mid(); chk("t5_abort_stb", 32'(s_stb_o), 32'd0);
    tick();
    m0_stb_i = 1'b1; m1_stb_i = 1'b1;
    mid(); chk("t5_idle_stb", 32'(s_stb_o), 32'd0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'h0000_7777;
    expect_ack(1'b0, 1'b0, 32'h0000_7777);
    mid(); chk("t5_regrant", 32'(gnt_o), 32'd1);
    tick();
    quiet();
    tick();

    // Reset during m1's bus cycle drops the bus at once; m0 wins afterwards.
    m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0050;
    tick();
    mid();
    chk("t6_busy_stb", 32'(s_stb_o), 32'd1);
    chk("t6_busy_gnt", 32'(gnt_o), 32'd2);
    #1;
    s_ack_i = 1'b1;
    rst_ni  = 1'b0;
    #1;
    chk("t6_rst_stb", 32'(s_stb_o), 32'd0);
    chk("t6_rst_gnt", 32'(gnt_o), 32'd0);
    chk("t6_rst_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    m0_stb_i = 1'b1;
    tick();
    tick();
    rst_ni = 1'b1;
    mid(); chk("t6_idle_stb", 32'(s_stb_o), 32'd0);
    tick();
    s_dat_i = 32'h0000_9999;
    expect_ack(1'b0, 1'b0, 32'h0000_9999);
    mid(); chk("t6_gnt", 32'(gnt_o), 32'd1);
    tick();
    quiet();
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
